dependency_pipeline: RTL and testbench



---
 rtl/dependency_pipeline.sv | 98 +++++++++
 tb/tb_dependency_pipeline.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dependency_pipeline.sv
// Read-after-write sequencer: computes -3*i through a 2-entry registered-read array,
// with an external port that may access the array only while the sequencer is idle.
module dependency_pipeline (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_enable,
    input  logic [63:0] init_i,
    output logic        w_enable,
    output logic [63:0] result,
    input  logic        controlArr,
    input  logic        controlArrWEnable_a,
    input  logic        controlArrAddr_a,
    input  logic [63:0] controlArrWData_a,
    output logic [63:0] controlArrRData_a
);
    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, SUM} state_t;

    state_t            state_q, state_d;
    logic [63:0]       i_q, t_q, result_q, rdata_q;
    logic              w_enable_q;
    logic [1:0][63:0]  mem_q;

    logic              port_en, port_we, port_addr;
    logic [63:0]       port_wdata;

    always_comb begin
        state_d    = state_q;
        port_en    = 1'b0;
        port_we    = 1'b0;
        port_addr  = 1'b0;
        port_wdata = 64'd0;
        case (state_q)
            IDLE: begin
                if (r_enable) state_d = W0;
                // External pins own the array only while no run is in flight
                if (controlArr) begin
                    port_en    = 1'b1;
                    port_we    = controlArrWEnable_a;
                    port_addr  = controlArrAddr_a;
                    port_wdata = controlArrWData_a;
                end
            end
            W0: begin
                port_en    = 1'b1;
                port_we    = 1'b1;
                port_addr  = 1'b0;
                port_wdata = -i_q;
                state_d    = R0;
            end
            R0: begin
                port_en   = 1'b1;
                port_addr = 1'b0;
                state_d   = W1;
            end
            W1: begin
                port_en    = 1'b1;
                port_we    = 1'b1;
                port_addr  = 1'b1;
                port_wdata = rdata_q + rdata_q;
                state_d    = R1;
            end
            R1: begin
                port_en   = 1'b1;
                port_addr = 1'b1;
                state_d   = SUM;
            end
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= 64'd0;
            t_q        <= 64'd0;
            result_q   <= 64'd0;
            rdata_q    <= 64'd0;
            w_enable_q <= 1'b0;
            mem_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && r_enable) i_q <= init_i;
            // Read-first port: a write cycle returns the old contents
            if (port_en) begin
                rdata_q <= mem_q[port_addr];
                if (port_we) mem_q[port_addr] <= port_wdata;
            end
            if (state_q == W1) t_q <= rdata_q;
            if (state_q == SUM) result_q <= rdata_q + t_q;
            w_enable_q <= (state_q == SUM);
        end
    end

    assign w_enable          = w_enable_q;
    assign result            = result_q;
    assign controlArrRData_a = rdata_q;
endmodule

// File: tb/tb_dependency_pipeline.sv
// Directed bench for dependency_pipeline: table of operands plus hand-written
// sequences for busy protection, reset abort, idle external access and back-to-back runs.
module tb_dependency_pipeline;
    logic        clk = 1'b0;
    logic        rst, r_enable, controlArr, controlArrWEnable_a, controlArrAddr_a;
    logic [63:0] init_i, controlArrWData_a;
    logic        w_enable;
    logic [63:0] result, controlArrRData_a;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dependency_pipeline dut (
        .clk                 (clk),
        .rst                 (rst),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .w_enable            (w_enable),
        .result              (result),
        .controlArr          (controlArr),
        .controlArrWEnable_a (controlArrWEnable_a),
        .controlArrAddr_a    (controlArrAddr_a),
        .controlArrWData_a   (controlArrWData_a),
        .controlArrRData_a   (controlArrRData_a)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] init;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; expects exactly one strobe five cycles after acceptance
    task automatic run(input string nm, input logic [63:0] v, input logic [63:0] exp);
        int lat, cnt;
        init_i   = v;
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        init_i   = ~v;
        lat = 0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (w_enable) begin
                cnt++;
                if (lat == 0) lat = k;
            end
        end
        check({nm, " latency"}, 64'(lat), 64'd5);
        check({nm, " strobes"}, 64'(cnt), 64'd1);
        check({nm, " result"}, result, exp);
    endtask

    task automatic ext_write(input logic a, input logic [63:0] d);
        controlArr          = 1'b1;
        controlArrWEnable_a = 1'b1;
        controlArrAddr_a    = a;
        controlArrWData_a   = d;
        tick();
        controlArrWEnable_a = 1'b0;
        controlArr          = 1'b0;
    endtask

    task automatic ext_read(input string nm, input logic a, input logic [63:0] exp);
        controlArr          = 1'b1;
        controlArrWEnable_a = 1'b0;
        controlArrAddr_a    = a;
        tick();
        check(nm, controlArrRData_a, exp);
        controlArr = 1'b0;
    endtask

    initial begin
        int cnt, lat;
        int t[3];
        logic [63:0] rr[3];

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd21};
        vecs[1] = '{64'd5,                   64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{64'd0,                   64'd0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0003};
        vecs[5] = '{64'd1,                   64'hFFFF_FFFF_FFFF_FFFD};

        rst = 1'b1; r_enable = 1'b0; init_i = '0; controlArr = 1'b0;
        controlArrWEnable_a = 1'b0; controlArrAddr_a = 1'b0; controlArrWData_a = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset w_enable", 64'(w_enable), 64'd0);
        check("reset result", result, 64'd0);
        check("reset rdata", controlArrRData_a, 64'd0);
        ext_read("reset mem0", 1'b0, 64'd0);
        ext_read("reset mem1", 1'b1, 64'd0);

        // Basic run and array contents afterwards
        run("basic", 64'hFFFF_FFFF_FFFF_FFF9, 64'd21);
        ext_read("basic mem0", 1'b0, 64'd7);
        ext_read("basic mem1", 1'b1, 64'd14);

        for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), vecs[i].init, vecs[i].exp);
        ext_read("wrap mem0", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

        // Busy protection: second start at E2 and external write of 999 during the run
        init_i = 64'hFFFF_FFFF_FFFF_FFF9;
        r_enable = 1'b1;
        tick();                                  // E0
        r_enable = 1'b0;
        controlArr = 1'b1; controlArrWEnable_a = 1'b1;
        controlArrAddr_a = 1'b0; controlArrWData_a = 64'd999;
        tick();                                  // E1
        r_enable = 1'b1;
        tick();                                  // E2
        r_enable = 1'b0;
        tick();                                  // E3
        controlArr = 1'b0; controlArrWEnable_a = 1'b0;
        cnt = 0; lat = 0;
        for (int k = 4; k <= 14; k++) begin
            tick();
            if (w_enable) begin
                cnt++;
                if (lat == 0) lat = k;
            end
        end
        check("busy strobes", 64'(cnt), 64'd1);
        check("busy latency", 64'(lat), 64'd5);
        check("busy result", result, 64'd21);
        ext_read("busy mem0", 1'b0, 64'd7);

        // Idle external access, then a run overwrites the stale entry
        ext_write(1'b1, 64'h1234);
        ext_read("ext rd mem1", 1'b1, 64'h1234);
        run("after ext", 64'hFFFF_FFFF_FFFF_FFF9, 64'd21);
        ext_read("after ext mem1", 1'b1, 64'd14);

        // Reset sampled at E3 aborts the run
        init_i = 64'd5;
        r_enable = 1'b1;
        tick();                                  // E0
        r_enable = 1'b0;
        tick(); tick();                          // E1, E2
        rst = 1'b1;
        tick();                                  // E3
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (w_enable) cnt++;
        end
        check("rst strobes", 64'(cnt), 64'd0);
        check("rst result", result, 64'd0);
        ext_read("rst mem0", 1'b0, 64'd0);
        ext_read("rst mem1", 1'b1, 64'd0);
        run("after rst", 64'hFFFF_FFFF_FFFF_FFF9, 64'd21);

        // Back-to-back: r_enable held high
        init_i = 64'd1;
        r_enable = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (w_enable && cnt < 3) begin
                t[cnt]  = cyc;
                rr[cnt] = result;
                cnt++;
                if (cnt == 3) r_enable = 1'b0;
            end
        end
        r_enable = 1'b0;
        check("b2b strobes", 64'(cnt), 64'd3);
        if (cnt == 3) begin
            check("b2b gap1", 64'(t[1] - t[0]), 64'd6);
            check("b2b gap2", 64'(t[2] - t[1]), 64'd6);
            for (int k = 0; k < 3; k++) check($sformatf("b2b result%0d", k), rr[k], 64'hFFFF_FFFF_FFFF_FFFD);
        end
        check("b2b idle after", 64'(w_enable), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
